mult_arbiter: RTL
=================

Name: mult_arbiter

Overview:
- Shares one unsigned Width x Width multiplier between NumReq requesters.
- Each requester has its own valid/ready request port. There is one shared response port, and it carries the requester ID.
- Sits between client blocks and the multiplier core. The multiplier is external and connected through mult_a_o / mult_b_o / mult_p_i.
- Round-robin grant, one operation in flight, and a fixed wait of MultLatency cycles for the multiplier result.

Parameters:
- NumReq, 4, number of requesters; legal range is 1 or more.
- Width, 8, operand width in bits; the product is 2*Width bits.
- MultLatency, 1, cycles from operands driven to mult_p_i valid; legal range is 1 or more.
- IdW, $clog2(NumReq) with a minimum of 1 (derived), width of the requester ID.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- req_valid_i  in  NumReq  per-requester request valid.
- req_ready_o  out  NumReq  per-requester accept; one-hot or zero.
- req_a_i  in  NumReq*Width  packed operand A; requester i occupies slice i.
- req_b_i  in  NumReq*Width  packed operand B; requester i occupies slice i.
- rsp_valid_o  out  1  result valid.
- rsp_ready_i  in  1  result consumed.
- rsp_id_o  out  IdW  index of the requester that owns the result.
- rsp_data_o  out  2*Width  unsigned product.
- mult_a_o  out  Width  registered operand A to the multiplier.
- mult_b_o  out  Width  registered operand B to the multiplier.
- mult_p_i  in  2*Width  product from the multiplier.
- busy_o  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset (rst_ni low, asynchronous):
  - State = IDLE; round-robin pointer = 0.
  - mult_a_o, mult_b_o, rsp_data_o, rsp_id_o, rsp_valid_o and busy_o are all 0.
  - Reset mid-operation aborts the operation. The result is discarded and no response is issued.
- States: IDLE, WAIT, RESP.
- IDLE:
  - req_ready_o[g] = 1 only in IDLE. g is the first asserted req_valid_i index at or after the pointer, searching upward and wrapping from NumReq-1 to 0.
  - With no valid requests, req_ready_o = 0 and the block stays in IDLE.
  - The grant is combinational each IDLE cycle. A requester that drops valid before its handshake simply loses the grant.
  - On a handshake (valid and ready) at edge k:
    - mult_a_o and mult_b_o latch slice g of req_a_i and req_b_i.
    - rsp_id_o latches g.
    - The wait counter loads MultLatency-1.
    - The state goes to WAIT.
- WAIT:
  - The counter decrements each cycle.
  - At edge k+MultLatency, rsp_data_o latches mult_p_i, rsp_valid_o goes to 1, and the state goes to RESP.
  - Accept-to-rsp_valid latency is exactly MultLatency cycles.
- RESP:
  - rsp_valid_o, rsp_id_o and rsp_data_o are held stable until rsp_ready_i is seen high.
  - On that handshake edge: rsp_valid_o goes to 0, the pointer becomes (rsp_id_o+1) mod NumReq, and the state returns to IDLE.
  - If rsp_ready_i is already high on the first RESP cycle, the response lasts one cycle.
- Throughput: at most one operation per MultLatency+2 cycles; there is no pipelining.
- mult_a_o and mult_b_o keep the last granted operands until the next grant; they are not cleared.
- Width rules: the multiplication is unsigned with no truncation. 255*255 = 65025 fits in 16 bits.
- NumReq = 1: the pointer stays 0, rsp_id_o is always 0, and IdW = 1.
- Fairness: a requester that holds valid is granted within NumReq grants.
- MultLatency = 0 is rejected by an elaboration-time assertion.

Optional Feature:
- Macro: MULT_ARBITER_STATS_EN.
- When defined:
  - Adds output port grant_cnt_o, NumReq*16 bits packed.
  - One counter per requester, incremented on each request handshake and saturating at 16'hFFFF.
  - Counters clear on reset.
  - Adds output port busy_cnt_o, 32 bits, which counts the cycles with busy_o high and wraps on overflow.
- When undefined: neither port exists and there are no counter flops.

Decomposition:
- Package mult_arbiter_pkg holds:
  - the state enum mult_arb_state_e {IDLE, WAIT, RESP};
  - the default width constants DefaultWidth = 8 and DefaultNumReq = 4;
  - StatCntW = 16;
  - the function id_width(n), returning the maximum of 1 and $clog2(n).
- Sub-module mult_arb_rr_pick: a combinational round-robin picker.
  - Inputs: request vector and pointer.
  - Outputs: one-hot grant, grant index and a valid flag.
  - It is unit-testable on its own.

Test Plan:
- Single request: requester 0 sends 2, 7 and the multiplier returns 14 → rsp_valid_o rises exactly MultLatency cycles after accept, with rsp_id_o = 0 and rsp_data_o = 14.
- All four requesters valid at once with pointer 0, operands (211,98), (123,77), (255,255), (0,0), rsp_ready_i held high → grants in order 0,1,2,3; responses 20678, 9471, 65025, 0 with IDs 0..3.
- Backpressure: rsp_ready_i low for 5 cycles in RESP → rsp_data_o and rsp_id_o stable, req_ready_o all 0; release → back to IDLE next cycle.
- Fairness: requesters 1 and 3 continuously valid → grants alternate 1,3,1,3 and pointer wrap from 3 to 0 is exercised.
- Reset mid-operation: assert rst_ni low in WAIT → all outputs 0 immediately; after release, no stale response and pointer = 0.
- MultLatency = 3 and NumReq = 1 build (with MULT_ARBITER_STATS_EN defined), operands 255 and 255 issued 10 times → each result 65025 at a latency of 3, grant_cnt_o = 10, and busy_cnt_o equals the number of cycles busy_o was high.

Source files
------------

// File: rtl/mult_arbiter_pkg.sv
// Shared types and constants for the round-robin multiplier arbiter.
// Holds the FSM state enum, default sizes and the requester-ID width helper.
package mult_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mult_arb_state_e;

  localparam int DefaultWidth  = 8;
  localparam int DefaultNumReq = 4;
  localparam int StatCntW      = 16;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mult_arb_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
// Zero latency; no backpressure of its own, vld is low when no request is set.
module mult_arb_rr_pick #(
  parameter int NumReq = 4,
  parameter int IdW    = 2
) (
  input  logic [NumReq-1:0] req,
  input  logic [IdW-1:0]    ptr,
  output logic [NumReq-1:0] gnt,
  output logic [IdW-1:0]    idx,
  output logic              vld
);

  int cand;

  // Walk offsets from farthest to nearest so the nearest set request wins.
  always_comb begin
    gnt  = '0;
    idx  = '0;
    vld  = 1'b0;
    cand = 0;
    for (int off = NumReq - 1; off >= 0; off--) begin
      cand = (int'(ptr) + off) % NumReq;
      if (req[cand]) begin
        gnt       = '0;
        gnt[cand] = 1'b1;
        idx       = IdW'(cand);
        vld       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin share of one external multiplier; accept-to-rsp_valid is MultLatency cycles, one op in flight.
// Requests wait (ready low) outside IDLE; the response holds until rsp_ready_i. MULT_ARBITER_STATS_EN adds counters.
module mult_arbiter
  import mult_arbiter_pkg::*;
#(
  parameter int  NumReq      = DefaultNumReq,
  parameter int  Width       = DefaultWidth,
  parameter int  MultLatency = 1,
  localparam int IdW         = id_width(NumReq)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NumReq-1:0]       req_valid_i,
  output logic [NumReq-1:0]       req_ready_o,
  input  logic [NumReq*Width-1:0] req_a_i,
  input  logic [NumReq*Width-1:0] req_b_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [IdW-1:0]          rsp_id_o,
  output logic [2*Width-1:0]      rsp_data_o,
  output logic [Width-1:0]        mult_a_o,
  output logic [Width-1:0]        mult_b_o,
  input  logic [2*Width-1:0]      mult_p_i,
  output logic                    busy_o
`ifdef MULT_ARBITER_STATS_EN
  ,
  output logic [NumReq*StatCntW-1:0] grant_cnt_o,
  output logic [31:0]                busy_cnt_o
`endif
);

  localparam int CntW = (MultLatency > 1) ? $clog2(MultLatency) : 1;

  if (MultLatency < 1) begin : g_bad_latency
    $error("mult_arbiter: MultLatency must be at least 1");
  end

  mult_arb_state_e      state_q, state_d;
  logic [IdW-1:0]       ptr_q;
  logic [CntW-1:0]      cnt_q;
  logic [NumReq-1:0]    pick_gnt;
  logic [IdW-1:0]       pick_idx;
  logic                 pick_vld;
  logic                 accept;
  logic [Width-1:0]     sel_a, sel_b;

  mult_arb_rr_pick #(
    .NumReq (NumReq),
    .IdW    (IdW)
  ) u_pick (
    .req (req_valid_i),
    .ptr (ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .vld (pick_vld)
  );

  assign req_ready_o = (state_q == IDLE) ? pick_gnt : '0;
  assign accept      = (state_q == IDLE) && pick_vld;
  assign busy_o      = (state_q != IDLE);

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NumReq; i++) begin
      if (pick_gnt[i]) begin
        sel_a = req_a_i[i*Width +: Width];
        sel_b = req_b_i[i*Width +: Width];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = WAIT;
      WAIT:    if (cnt_q == '0) state_d = RESP;
      RESP:    if (rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operands stay on the multiplier inputs after the op; only a new grant changes them.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mult_a_o    <= '0;
      mult_b_o    <= '0;
      rsp_id_o    <= '0;
      rsp_data_o  <= '0;
      rsp_valid_o <= 1'b0;
      cnt_q       <= '0;
      ptr_q       <= '0;
    end else begin
      if (accept) begin
        mult_a_o <= sel_a;
        mult_b_o <= sel_b;
        rsp_id_o <= pick_idx;
        cnt_q    <= CntW'(MultLatency - 1);
      end
      if (state_q == WAIT) begin
        if (cnt_q == '0) begin
          rsp_data_o  <= mult_p_i;
          rsp_valid_o <= 1'b1;
        end else begin
          cnt_q <= cnt_q - CntW'(1);
        end
      end
      if (state_q == RESP && rsp_ready_i) begin
        rsp_valid_o <= 1'b0;
        if (rsp_id_o == IdW'(NumReq - 1)) ptr_q <= '0;
        else                             ptr_q <= rsp_id_o + IdW'(1);
      end
    end
  end

`ifdef MULT_ARBITER_STATS_EN
  logic [StatCntW-1:0] gcnt_q [NumReq];
  logic [31:0]         bcnt_q;

  // Grant counters saturate so a long run never reports a small wrapped value.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumReq; i++) gcnt_q[i] <= '0;
      bcnt_q <= '0;
    end else begin
      for (int i = 0; i < NumReq; i++) begin
        if (accept && pick_gnt[i] && (gcnt_q[i] != '1)) gcnt_q[i] <= gcnt_q[i] + 1'b1;
      end
      if (busy_o) bcnt_q <= bcnt_q + 32'd1;
    end
  end

  for (genvar g = 0; g < NumReq; g++) begin : g_gcnt
    assign grant_cnt_o[g*StatCntW +: StatCntW] = gcnt_q[g];
  end
  assign busy_cnt_o = bcnt_q;
`endif

endmodule
